// File: rtl/tx_uart_128.sv
// Serialises a 128-bit word as 16 8N1 UART frames, MSB byte first, LSB bit first.
// Latency: line goes low the edge after accept; tx_done 160*CLKS_PER_BIT cycles later.
// Backpressure: start is ignored while busy or with en_tx low; en_tx low aborts at the next byte boundary.
module tx_uart_128 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_tx,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         u_tx,
  output logic         busy,
  output logic         byte_done,
  output logic         tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [127:0]        word_q, word_d;
  logic [3:0]          byte_cnt_q, byte_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic                u_tx_q, u_tx_d;
  logic                busy_q, busy_d;
  logic                byte_done_q, byte_done_d;
  logic                tx_done_q, tx_done_d;

  logic                baud_last;
  logic [7:0]          cur_byte;

  assign baud_last = (baud_cnt_q == BAUD_LAST);
  // The word shifts left by a byte per frame, so the byte on the wire is always the top one.
  assign cur_byte  = word_q[127:120];

  // u_tx_d is the line level for the state being entered, keeping u_tx aligned with state_q.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    u_tx_d      = u_tx_q;
    byte_done_d = 1'b0;
    tx_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        u_tx_d     = 1'b1;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        if (start && en_tx) begin
          word_d  = data_in;
          state_d = START;
          u_tx_d  = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
          u_tx_d     = cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            u_tx_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            u_tx_d    = cur_byte[bit_cnt_d];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_d  = '0;
          byte_done_d = 1'b1;
          if (byte_cnt_q == 4'd15) begin
            tx_done_d  = 1'b1;
            byte_cnt_d = '0;
            state_d    = IDLE;
            u_tx_d     = 1'b1;
          end else if (en_tx) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            word_d     = {word_q[119:0], 8'h00};
            state_d    = START;
            u_tx_d     = 1'b0;
          end else begin
            byte_cnt_d = '0;
            state_d    = IDLE;
            u_tx_d     = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        u_tx_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      u_tx_q      <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      u_tx_q      <= u_tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign u_tx      = u_tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign tx_done   = tx_done_q;

endmodule
